// File: rtl/source_seq.sv
// source_seq
//
// Frame sequencer for the speech synthesiser's excitation source. It accepts
// frame commands (pitch period, amplitude, duration) over a valid/ready
// handshake. It generates the sample strobe and drives period/amplitude to
// the SOURCE block. On each strobe, amplitude steps toward the frame target.
// When no frame is pending, amplitude fades to silence. A single holding
// register lets the next frame follow the current one without a gap.
//
// Ports:
//   clk           system clock
//   rst_an        synchronous active-low reset, overrides every other input
//   frame_valid   frame command offered
//   frame_ready   hold register empty, command can be taken (combinational)
//   frame_period  pitch period in samples, 0 selects noise mode
//   frame_amp     signed target amplitude, negatives clamp to 0 at capture
//   frame_dur     frame length in strobes, 0 behaves as 1
//   period        registered pitch period to SOURCE
//   amplitude     registered amplitude to SOURCE, always 0..16383
//   strobe        registered one-cycle sample strobe
//   busy          a frame is running or one is waiting in the hold register
//   underrun      one-cycle pulse when a frame ends with no successor
module source_seq #(
  parameter int CLKDIV    = 5,
  parameter int RAMP_STEP = 0
) (
  input  logic               clk,
  input  logic               rst_an,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic [7:0]         frame_period,
  input  logic signed [14:0] frame_amp,
  input  logic [7:0]         frame_dur,
  output logic [7:0]         period,
  output logic signed [14:0] amplitude,
  output logic               strobe,
  output logic               busy,
  output logic               underrun
);

  localparam int               DIV_W    = $clog2(CLKDIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [15:0]      STEP     = 16'(RAMP_STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             strobe_q;

  logic             hold_valid_q;
  logic [7:0]       hold_period_q;
  logic [14:0]      hold_amp_q;
  logic [7:0]       hold_dur_q;
  logic             accept;
  logic             load;

  logic [7:0]       period_q, period_d;
  logic [14:0]      amp_q, amp_d;
  logic [14:0]      target_q, target_d;
  logic [7:0]       dur_q, dur_d;
  logic             underrun_q, underrun_d;

  // Moves one strobe's worth toward tgt without overshooting.
  // The arithmetic uses 16 bits so cur + STEP cannot wrap.
  function automatic logic [14:0] step_toward(input logic [14:0] cur,
                                              input logic [14:0] tgt);
    logic [15:0] c;
    logic [15:0] t;
    logic [15:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    r = t;
    if (STEP != 16'd0) begin
      if (c < t) begin
        r = c + STEP;
        if (r > t) r = t;
      end else if (c > t) begin
        if ((c - t) > STEP) r = c - STEP;
        else                r = t;
      end
    end
    return r[14:0];
  endfunction

  assign tick        = (div_q == DIV_LAST);
  assign accept      = frame_valid && !hold_valid_q;
  assign frame_ready = !hold_valid_q;
  assign busy        = (state_q == RUN) || hold_valid_q;

  assign period      = period_q;
  assign amplitude   = amp_q;
  assign strobe      = strobe_q;
  assign underrun    = underrun_q;

  // Free-running divider and the strobe.
  // Both run in every state. The strobe register goes high on the same edge
  // that commits new frame values, so SOURCE sees the values with the strobe.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      div_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      div_q    <= tick ? '0 : div_q + DIV_W'(1);
      strobe_q <= tick;
    end
  end

  // Hold register.
  // A load only happens while hold_valid is set, and an accept only happens
  // while it is clear, so the two can never collide on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      hold_valid_q  <= 1'b0;
      hold_period_q <= '0;
      hold_amp_q    <= '0;
      hold_dur_q    <= '0;
    end else if (accept) begin
      hold_valid_q  <= 1'b1;
      hold_period_q <= frame_period;
      hold_amp_q    <= frame_amp[14] ? 15'd0 : frame_amp;
      hold_dur_q    <= frame_dur;
    end else if (load) begin
      hold_valid_q  <= 1'b0;
    end
  end

  // Sequencer next-state logic.
  // On a strobe edge, a running frame with strobes left keeps stepping.
  // Otherwise the held frame is loaded. If nothing is held, the sequencer
  // fades to silence and flags the underrun (only when leaving RUN).
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    amp_d      = amp_q;
    target_d   = target_q;
    dur_d      = dur_q;
    load       = 1'b0;
    underrun_d = 1'b0;
    if (tick) begin
      if ((state_q == RUN) && (dur_q > 8'd1)) begin
        dur_d = dur_q - 8'd1;
        amp_d = step_toward(amp_q, target_q);
      end else if (hold_valid_q) begin
        load     = 1'b1;
        state_d  = RUN;
        period_d = hold_period_q;
        target_d = hold_amp_q;
        dur_d    = (hold_dur_q == 8'd0) ? 8'd1 : hold_dur_q;
        amp_d    = step_toward(amp_q, hold_amp_q);
      end else begin
        state_d    = IDLE;
        target_d   = '0;
        amp_d      = step_toward(amp_q, 15'd0);
        underrun_d = (state_q == RUN);
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state_q    <= IDLE;
      period_q   <= '0;
      amp_q      <= '0;
      target_q   <= '0;
      dur_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      amp_q      <= amp_d;
      target_q   <= target_d;
      dur_q      <= dur_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: doc/source_seq.md
# source_seq

Frame sequencer for the excitation source of the speech synthesiser. Accepts frame commands (pitch period, amplitude, duration) over a valid/ready handshake. Generates the sample strobe and drives `period`, `amplitude` and `strobe` of the `SOURCE` block, stepping amplitude toward each target and fading to silence when no frame is pending. One holding register allows back-to-back frames without gaps.

## Interface
- `CLKDIV`, 5: clock cycles per sample strobe; must be ≥ 2.
- `RAMP_STEP`, 0: maximum amplitude change per strobe, 0..16383. A value of 0 means the amplitude jumps to the target immediately.
- `clk`  in  1  system clock.
- `rst_an`  in  1  reset. Synchronous, active-low; takes priority over all other inputs.
- `frame_valid`  in  1  frame command offered.
- `frame_ready`  out  1  equal to `!hold_valid` (combinational). Handshakes are ignored while `rst_an` = 0.
- `frame_period`  in  8  pitch period in samples. 0 selects noise mode.
- `frame_amp`  in  15  signed target amplitude. Negative values are clamped to 0 at capture.
- `frame_dur`  in  8  frame length in strobes. 0 is treated as 1.
- `period`  out  8  to `SOURCE`; registered.
- `amplitude`  out  15  signed, to `SOURCE`; registered; always in the range 0..16383.
- `strobe`  out  1  one-cycle sample strobe; registered.
- `busy`  out  1  high when state is RUN or `hold_valid` is set.
- `underrun`  out  1  one-cycle pulse when a frame ends with no successor.

## Operation
- **Divider.** `div_cnt` counts 0..CLKDIV-1 and wraps. `strobe` is registered high on the edge where `div_cnt` reaches CLKDIV-1. The divider runs freely in every state.
- **Hold register.** Captures {period, clamped amp, dur} on an edge with `frame_valid` && `frame_ready`, and sets `hold_valid`. It is cleared only by a load. Accepting and loading never coincide, because a load reads the contents held before that edge.
- **FSM states:** IDLE and RUN. All state, `period` and `amplitude` updates occur only on strobe edges, i.e. the same edge that raises `strobe`. `SOURCE` therefore sees new values together with the strobe, and the values stay stable for the full interval.
- **Strobe edge, RUN with `dur_cnt` > 1:** `dur_cnt` decrements; `amplitude` steps toward `target`.
- **Strobe edge, RUN with `dur_cnt` = 1, or IDLE:**
  - If `hold_valid`: load. `period` ← hold.period; `target` ← hold.amp; `dur_cnt` ← hold.dur (0→1); `amplitude` steps toward the new target; `hold_valid` clears; state goes to RUN.
  - Otherwise: state goes to IDLE; `target` ← 0; `amplitude` steps toward 0; `period` is held. `underrun` pulses for 1 cycle only on the RUN→IDLE transition.
- **Step rule:**
  - If `amplitude` < `target`: new value = min(`amplitude` + RAMP_STEP, `target`).
  - If `amplitude` > `target`: new value = max(`amplitude` − RAMP_STEP, `target`).
  - If RAMP_STEP = 0: new value = `target`.
  - Compute in 16 bits; the result never overshoots the target or goes negative.
- **Frame length.** A loaded frame occupies exactly `dur` strobes; the load strobe counts as the first.

## Timing
- **Reset values:** `period` = 0, `amplitude` = 0, `strobe` = 0, `underrun` = 0, `div_cnt` = 0, state IDLE, `hold_valid` = 0. Therefore `frame_ready` = 1 and `busy` = 0.
- **First strobe:** on the CLKDIV-th edge after the first edge with `rst_an` = 1, then every CLKDIV cycles.
- **Load latency:** a frame accepted while idle loads on the next strobe edge strictly after the accepting edge. A frame accepted on a strobe edge waits one full interval.
- **`frame_ready` timing:** `frame_ready` falls the cycle after acceptance. It rises the cycle after the load edge.
- **Seamless succession:** if the hold register is valid when the current frame's last strobe edge occurs, the next frame's first sample uses the new parameters with no IDLE strobe between frames and no `underrun`.
- **Reset mid-frame:** all registers return to their reset values, the hold contents are discarded, and the divider restarts.

## Test plan
1. **Reset.** Hold `rst_an` = 0 for 3 cycles, then release. Check: all outputs = 0, `frame_ready` = 1, `strobe` pulses on edges 5, 10, 15 (CLKDIV = 5).
2. **Single frame, RAMP_STEP = 0.** Send frame (50, 15000, 3) while idle. Check:
   - the next strobe shows `period` = 50, `amplitude` = 15000 for 3 strobes;
   - the 4th strobe shows `amplitude` = 0, `period` stays 50, `underrun` pulses once;
   - `busy` is high from acceptance through the 3rd strobe interval.
3. **Back-to-back.** Send A (50, 15000, 2) and B (0, 8000, 2) consecutively. Check:
   - B is stalled (`frame_ready` = 0) until A loads;
   - strobes 1–2 show 50/15000, strobes 3–4 show 0/8000;
   - no `underrun` between A and B, and one `underrun` after B.
4. **Ramp, RAMP_STEP = 4096.** Send frame (60, 15000, 4). Check:
   - rising amplitude 4096, 8192, 12288, 15000;
   - then in IDLE: 10904, 6808, 2712, 0, and 0 thereafter.
5. **Edge values.** Frame (40, −200, 0). Check: exactly one strobe with `period` = 40 and `amplitude` = 0, then IDLE with `underrun`.
6. **Reset mid-operation.** Assert `rst_an` = 0 during the 2nd strobe interval of a frame with a successor held. Check:
   - outputs return to 0 and `frame_ready` = 1;
   - the held frame never appears;
   - the first strobe occurs 5 edges after release.
